// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: turns one memory request at a time into
// ACTIVATE/READ/WRITE/PRECHARGE commands with per-bank open-row tracking.
// Ports: clk_in, rst_in (async, active-high); req_valid_in/req_ready_out,
//   req_addr_in, req_write_in, req_data_in (request side);
//   cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out,
//   val_out (command sender side); row_hit_cnt_out (saturating hit count).
// Option: define SCHED_CLOSE_PAGE_EN to precharge the bank after every
//   column command (close-page policy); default is open-page.
module dram_cmd_scheduler #(
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int PADDR_BITS         = 64,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 4,
  localparam int BGW = $clog2(BANK_GROUPS),
  localparam int BAW = $clog2(BANKS_PER_GROUP)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic                  req_write_in,
  input  logic [7:0][63:0]      req_data_in,
  output logic                  cmd_valid_out,
  output logic [2:0]            cmd_out,
  output logic [BGW-1:0]        bank_group_out,
  output logic [BAW-1:0]        bank_out,
  output logic [ROW_BITS-1:0]   row_out,
  output logic [COL_BITS-1:0]   col_out,
  output logic [7:0][63:0]      val_out,
  output logic [15:0]           row_hit_cnt_out
);

  localparam int NB   = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IW   = BGW + BAW;
  localparam int AW   = COL_BITS + BAW + BGW + ROW_BITS;
  localparam int TMAX = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                        ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int GW   = $clog2(BURST_CYCLES + 1);

  localparam logic [2:0] C_RD  = 3'd0;
  localparam logic [2:0] C_WR  = 3'd1;
  localparam logic [2:0] C_ACT = 3'd2;
  localparam logic [2:0] C_PRE = 3'd3;
  localparam logic [2:0] C_NOP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_COL
`ifdef SCHED_CLOSE_PAGE_EN
    , S_AUTO_PRE
`endif
  } state_t;

  state_t                state;
  logic [COL_BITS-1:0]   r_col;
  logic [BAW-1:0]        r_ba;
  logic [BGW-1:0]        r_bg;
  logic [ROW_BITS-1:0]   r_row;
  logic                  r_write;
  logic [7:0][63:0]      r_data;
  logic [TW-1:0]         timer;
  logic [GW-1:0]         gap;
  logic                  pre_to_idle;
  logic [NB-1:0]         bank_open;
  logic [ROW_BITS-1:0]   bank_row [NB];

  logic [IW-1:0]         r_idx;
  logic                  hit;
  logic                  gap_ok;
  logic                  timer_ok;
  logic [2:0]            col_op;
  logic                  go;
  logic [2:0]            go_op;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr_in[PADDR_BITS-1:AW];

  assign r_idx  = {r_bg, r_ba};
  assign hit    = bank_open[r_idx] && (bank_row[r_idx] == r_row);
  assign col_op = r_write ? C_WR : C_RD;
  // Outputs are registered, so the issue decision is made one cycle
  // ahead: a counter at 1 now is 0 in the cycle the command appears.
  assign gap_ok   = (gap <= GW'(1));
  assign timer_ok = (timer <= TW'(1));

  always_comb begin
    go    = 1'b0;
    go_op = C_NOP;
    case (state)
      S_CHECK: begin
        if (hit) begin
          go    = gap_ok;
          go_op = col_op;
        end else if (bank_open[r_idx]) begin
          go    = 1'b1;
          go_op = C_PRE;
        end else begin
          go    = 1'b1;
          go_op = C_ACT;
        end
      end
      S_PRE: begin
        go    = (PRECHARGE_LATENCY <= 1);
        go_op = C_ACT;
      end
      S_PRE_WAIT: begin
        go    = timer_ok && !pre_to_idle;
        go_op = C_ACT;
      end
      S_ACT: begin
        go    = (ACTIVATION_LATENCY <= 1) && gap_ok;
        go_op = col_op;
      end
      S_ACT_WAIT: begin
        go    = timer_ok && gap_ok;
        go_op = col_op;
      end
      S_COL: begin
        go    = !cmd_valid_out && gap_ok;
        go_op = col_op;
      end
`ifdef SCHED_CLOSE_PAGE_EN
      S_AUTO_PRE: begin
        go    = !cmd_valid_out && gap_ok;
        go_op = C_PRE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      req_ready_out   <= 1'b1;
      cmd_valid_out   <= 1'b0;
      cmd_out         <= C_NOP;
      bank_group_out  <= '0;
      bank_out        <= '0;
      row_out         <= '0;
      col_out         <= '0;
      val_out         <= '0;
      row_hit_cnt_out <= '0;
      timer           <= '0;
      pre_to_idle     <= 1'b0;
      bank_open       <= '0;
      r_col           <= '0;
      r_ba            <= '0;
      r_bg            <= '0;
      r_row           <= '0;
      r_write         <= 1'b0;
      r_data          <= '0;
    end else begin
      cmd_valid_out <= go;
      cmd_out       <= go ? go_op : C_NOP;
      val_out       <= (go && go_op == C_WR) ? r_data : '0;
      if (go) begin
        bank_group_out <= r_bg;
        bank_out       <= r_ba;
        row_out        <= r_row;
        col_out        <= r_col;
      end
      case (state)
        S_IDLE: begin
          if (req_valid_in && req_ready_out) begin
            r_col         <= req_addr_in[COL_BITS-1:0];
            r_ba          <= req_addr_in[COL_BITS +: BAW];
            r_bg          <= req_addr_in[COL_BITS+BAW +: BGW];
            r_row         <= req_addr_in[COL_BITS+BAW+BGW +: ROW_BITS];
            r_write       <= req_write_in;
            r_data        <= req_data_in;
            req_ready_out <= 1'b0;
            state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            if (row_hit_cnt_out != 16'hFFFF)
              row_hit_cnt_out <= row_hit_cnt_out + 16'd1;
            state <= S_COL;
          end else if (bank_open[r_idx]) begin
            state <= S_PRE;
          end else begin
            state <= S_ACT;
          end
        end
        S_PRE: begin
          bank_open[r_idx] <= 1'b0;
          timer            <= TW'(PRECHARGE_LATENCY - 1);
          state            <= go ? S_ACT : S_PRE_WAIT;
        end
        S_PRE_WAIT: begin
          if (timer_ok) begin
            if (pre_to_idle) begin
              pre_to_idle   <= 1'b0;
              req_ready_out <= 1'b1;
              state         <= S_IDLE;
            end else begin
              state <= S_ACT;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_ACT: begin
          bank_open[r_idx] <= 1'b1;
          timer            <= TW'(ACTIVATION_LATENCY - 1);
          state            <= (ACTIVATION_LATENCY <= 1) ? S_COL : S_ACT_WAIT;
        end
        S_ACT_WAIT: begin
          if (timer_ok) state <= S_COL;
          else timer <= timer - TW'(1);
        end
        S_COL: begin
          if (cmd_valid_out) begin
`ifdef SCHED_CLOSE_PAGE_EN
            state <= S_AUTO_PRE;
`else
            req_ready_out <= 1'b1;
            state         <= S_IDLE;
`endif
          end
        end
`ifdef SCHED_CLOSE_PAGE_EN
        S_AUTO_PRE: begin
          if (cmd_valid_out) begin
            bank_open[r_idx] <= 1'b0;
            timer            <= TW'(PRECHARGE_LATENCY - 1);
            pre_to_idle      <= 1'b1;
            state            <= S_PRE_WAIT;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row tags need no reset: they are only consulted while the
  // matching open flag is set.
  always_ff @(posedge clk_in) begin
    if (state == S_ACT) bank_row[r_idx] <= r_row;
  end

  // Column-to-column spacing, shared by all banks.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gap <= '0;
    end else if (cmd_valid_out && (cmd_out == C_RD || cmd_out == C_WR)) begin
      gap <= GW'(BURST_CYCLES - 1);
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: directed self-checking bench for
// dram_cmd_scheduler (open-page, or close-page with SCHED_CLOSE_PAGE_EN).
module tb_dram_cmd_scheduler;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            req_valid_in;
  logic            req_ready_out;
  logic [63:0]     req_addr_in;
  logic            req_write_in;
  logic [7:0][63:0] req_data_in;
  logic            cmd_valid_out;
  logic [2:0]      cmd_out;
  logic [1:0]      bank_group_out;
  logic [0:0]      bank_out;
  logic [7:0]      row_out;
  logic [3:0]      col_out;
  logic [7:0][63:0] val_out;
  logic [15:0]     row_hit_cnt_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  logic [7:0][63:0] wdata;
  logic [7:0][63:0] zdata;

  dram_cmd_scheduler dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_addr_in     (req_addr_in),
    .req_write_in    (req_write_in),
    .req_data_in     (req_data_in),
    .cmd_valid_out   (cmd_valid_out),
    .cmd_out         (cmd_out),
    .bank_group_out  (bank_group_out),
    .bank_out        (bank_out),
    .row_out         (row_out),
    .col_out         (col_out),
    .val_out         (val_out),
    .row_hit_cnt_out (row_hit_cnt_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge once ready; t0 marks cycle 0.
  task automatic send(input string tag, input logic [63:0] a,
                      input logic w, input logic [7:0][63:0] d);
    int n = 0;
    while (!req_ready_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_ready_wait"}, 64'(req_ready_out), 64'd1);
    req_valid_in = 1'b1;
    req_addr_in  = a;
    req_write_in = w;
    req_data_in  = d;
    t0           = cyc;
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  // Advance to the next command and check opcode, cycle offset and bank.
  task automatic expect_cmd(input string tag, input logic [2:0] op,
                            input int off, input logic [1:0] bg,
                            input logic ba);
    int n = 0;
    @(negedge clk_in);
    while (!cmd_valid_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_cmd"}, 64'(cmd_out), 64'(op));
    chk({tag, "_cyc"}, 64'(cyc - t0), 64'(off));
    chk({tag, "_bg"}, 64'(bank_group_out), 64'(bg));
    chk({tag, "_ba"}, 64'(bank_out), 64'(ba));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) wdata[i] = 64'(i);
    zdata        = '0;
    rst_in       = 1'b1;
    req_valid_in = 1'b0;
    req_addr_in  = '0;
    req_write_in = 1'b0;
    req_data_in  = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", 64'(req_ready_out), 64'd1);
    chk("rst_valid", 64'(cmd_valid_out), 64'd0);
    chk("rst_cmd", 64'(cmd_out), 64'd7);
    chk("rst_bg", 64'(bank_group_out), 64'd0);
    chk("rst_ba", 64'(bank_out), 64'd0);
    chk("rst_row", 64'(row_out), 64'd0);
    chk("rst_col", 64'(col_out), 64'd0);
    chk("rst_val", 64'(val_out == '0), 64'd1);
    chk("rst_hits", 64'(row_hit_cnt_out), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

`ifdef SCHED_CLOSE_PAGE_EN
    send("c1", 64'h000, 1'b0, zdata);
    expect_cmd("c1_act", 3'd2, 2, 2'd0, 1'b0);
    expect_cmd("c1_rd", 3'd0, 10, 2'd0, 1'b0);
    expect_cmd("c1_pre", 3'd3, 14, 2'd0, 1'b0);
    begin
      int n = 0;
      while (!req_ready_out && n < 40) begin
        @(negedge clk_in);
        n++;
      end
      chk("c1_ready_cyc", 64'(cyc - t0), 64'd19);
    end
    send("c2", 64'h000, 1'b0, zdata);
    expect_cmd("c2_act", 3'd2, 2, 2'd0, 1'b0);
    expect_cmd("c2_rd", 3'd0, 10, 2'd0, 1'b0);
    chk("c2_hits", 64'(row_hit_cnt_out), 64'd0);
`else
    send("t1", 64'h000, 1'b0, zdata);
    expect_cmd("t1_act", 3'd2, 2, 2'd0, 1'b0);
    chk("t1_act_row", 64'(row_out), 64'd0);
    expect_cmd("t1_rd", 3'd0, 10, 2'd0, 1'b0);
    chk("t1_rd_col", 64'(col_out), 64'd0);
    chk("t1_busy", 64'(req_ready_out), 64'd0);
    @(negedge clk_in);
    chk("t1_ready", 64'(req_ready_out), 64'd1);
    chk("t1_nop", 64'(cmd_out), 64'd7);
    chk("t1_nop_valid", 64'(cmd_valid_out), 64'd0);

    // Hit on row 0: stalls until 4 cycles after the previous READ.
    send("t2", 64'h003, 1'b0, zdata);
    expect_cmd("t2_rd", 3'd0, 3, 2'd0, 1'b0);
    chk("t2_col", 64'(col_out), 64'd3);
    chk("t2_hits", 64'(row_hit_cnt_out), 64'd1);

    // 0x100 maps to row 2 of bg0/ba0: conflict with open row 0.
    send("t3", 64'h100, 1'b1, wdata);
    expect_cmd("t3_pre", 3'd3, 2, 2'd0, 1'b0);
    expect_cmd("t3_act", 3'd2, 7, 2'd0, 1'b0);
    chk("t3_act_row", 64'(row_out), 64'd2);
    expect_cmd("t3_wr", 3'd1, 15, 2'd0, 1'b0);
    chk("t3_val_w3", val_out[3], 64'd3);
    chk("t3_val_w7", val_out[7], 64'd7);
    @(negedge clk_in);
    chk("t3_val_clr", 64'(val_out == '0), 64'd1);

    send("t4a", 64'h010, 1'b0, zdata);
    expect_cmd("t4a_act", 3'd2, 2, 2'd0, 1'b1);
    expect_cmd("t4a_rd", 3'd0, 10, 2'd0, 1'b1);
    send("t4b", 64'h020, 1'b0, zdata);
    expect_cmd("t4b_act", 3'd2, 2, 2'd1, 1'b0);
    expect_cmd("t4b_rd", 3'd0, 10, 2'd1, 1'b0);
    send("t4c", 64'h015, 1'b0, zdata);
    expect_cmd("t4c_rd", 3'd0, 3, 2'd0, 1'b1);
    chk("t4c_col", 64'(col_out), 64'd5);
    send("t4d", 64'h02A, 1'b0, zdata);
    expect_cmd("t4d_rd", 3'd0, 3, 2'd1, 1'b0);
    chk("t4d_col", 64'(col_out), 64'ha);
    chk("t4_hits", 64'(row_hit_cnt_out), 64'd3);

    // Reset while waiting out the activation latency.
    send("t5", 64'h040, 1'b0, zdata);
    expect_cmd("t5_act", 3'd2, 2, 2'd2, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(cmd_valid_out), 64'd0);
    chk("t5_rst_cmd", 64'(cmd_out), 64'd7);
    chk("t5_rst_ready", 64'(req_ready_out), 64'd1);
    chk("t5_rst_hits", 64'(row_hit_cnt_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    send("t6", 64'h040, 1'b0, zdata);
    expect_cmd("t6_act", 3'd2, 2, 2'd2, 1'b0);
    expect_cmd("t6_rd", 3'd0, 10, 2'd2, 1'b0);
    send("t7", 64'h000, 1'b0, zdata);
    expect_cmd("t7_act", 3'd2, 2, 2'd0, 1'b0);
    chk("t7_hits", 64'(row_hit_cnt_out), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
